// File: rtl/cdecv_datapath.sv
// -----------------------------------------------------------------------------
// cdecv_datapath
//
// Register and ALU datapath of the CDEC-V educational CPU. The controller
// presents one control word per state (changed on the falling edge); this
// block samples it on the rising edge.
//
// A single 8-bit X bus is driven by the source chosen with xsrc. Any subset of
// destination registers loads from it on the next rising edge. R captures the
// ALU result and FLG captures the ALU flags. The ALU operands are T (left) and
// X (right).
//
// Optional feature macro: CYCLE_COUNTER_EN
//   When defined, this adds a 16-bit free-running cycle counter on port
//   'cycles'. The counter can be held with pause_cc.
//   When undefined, the 'cycles' port is absent and pause_cc is ignored.
//
// Ports
//   clock      in   1   system clock, all registers capture on rising edge
//   reset      in   1   asynchronous, active-high reset
//   xsrc       in   3   X-bus source: 0 PC, 1 A, 2 B, 3 C, 4 mem_rdata, 5 R,
//                       6 {5'b0, FLG}, 7 8'hFF
//   xdst       in  10   load enables: 9 FLG, 8 R, 7 T, 6 I, 5 WD, 4 MA,
//                       3 C, 2 B, 1 A, 0 PC
//   aluop      in   4   ALU operation
//   mem_rdata  in   8   memory read data (combinational)
//   pause_cc   in   1   cycle-counter pause
//   mem_addr   out  8   MA register
//   mem_wdata  out  8   WD register
//   I          out  8   instruction register
//   SZCy       out  3   flag register {S, Z, Cy}
//   pc,a,b,c   out  8   monitor taps of PC, A, B, C
//   cycles     out 16   cycle count (CYCLE_COUNTER_EN only)
// -----------------------------------------------------------------------------
module cdecv_datapath (
  input  logic        clock,
  input  logic        reset,
  input  logic [2:0]  xsrc,
  input  logic [9:0]  xdst,
  input  logic [3:0]  aluop,
  input  logic [7:0]  mem_rdata,
  input  logic        pause_cc,
  output logic [7:0]  mem_addr,
  output logic [7:0]  mem_wdata,
  output logic [7:0]  I,
  output logic [2:0]  SZCy,
  output logic [7:0]  pc,
  output logic [7:0]  a,
  output logic [7:0]  b,
  output logic [7:0]  c
`ifdef CYCLE_COUNTER_EN
  ,
  output logic [15:0] cycles
`endif
);

  // X-bus source codes
  localparam logic [2:0] XS_PC  = 3'd0;
  localparam logic [2:0] XS_A   = 3'd1;
  localparam logic [2:0] XS_B   = 3'd2;
  localparam logic [2:0] XS_C   = 3'd3;
  localparam logic [2:0] XS_RD  = 3'd4;
  localparam logic [2:0] XS_R   = 3'd5;
  localparam logic [2:0] XS_FLG = 3'd6;
  localparam logic [2:0] XS_FF  = 3'd7;

  // Bit positions of the load enables within xdst
  localparam int unsigned EN_PC  = 0;
  localparam int unsigned EN_A   = 1;
  localparam int unsigned EN_B   = 2;
  localparam int unsigned EN_C   = 3;
  localparam int unsigned EN_MA  = 4;
  localparam int unsigned EN_WD  = 5;
  localparam int unsigned EN_I   = 6;
  localparam int unsigned EN_T   = 7;
  localparam int unsigned EN_R   = 8;
  localparam int unsigned EN_FLG = 9;

  // ALU operation codes (11..15 fall through to PASS)
  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_INC  = 4'd5;
  localparam logic [3:0] OP_DEC  = 4'd6;
  localparam logic [3:0] OP_PASS = 4'd7;
  localparam logic [3:0] OP_NOT  = 4'd8;
  localparam logic [3:0] OP_SHL  = 4'd9;
  localparam logic [3:0] OP_SHR  = 4'd10;

  // Architectural registers
  logic [7:0] pc_q,  pc_d;
  logic [7:0] a_q,   a_d;
  logic [7:0] b_q,   b_d;
  logic [7:0] c_q,   c_d;
  logic [7:0] ma_q,  ma_d;
  logic [7:0] wd_q,  wd_d;
  logic [7:0] i_q,   i_d;
  logic [7:0] t_q,   t_d;
  logic [7:0] r_q,   r_d;
  logic [2:0] flg_q, flg_d;

  // Combinational bus and ALU signals
  logic [7:0] x_s;
  logic [8:0] alu_sum_s;    // bit 8 is carry/borrow out
  logic [7:0] alu_res_s;
  logic       alu_cy_s;
  logic [2:0] alu_flg_s;

  // X-bus source multiplexer
  always_comb begin
    x_s = 8'h00;
    case (xsrc)
      XS_PC:   x_s = pc_q;
      XS_A:    x_s = a_q;
      XS_B:    x_s = b_q;
      XS_C:    x_s = c_q;
      XS_RD:   x_s = mem_rdata;
      XS_R:    x_s = r_q;
      XS_FLG:  x_s = {5'b00000, flg_q};
      XS_FF:   x_s = 8'hFF;
      default: x_s = 8'h00;
    endcase
  end

  // ALU: arithmetic ops run through a 9-bit sum so that bit 8 yields the carry.
  // For SUB and DEC, bit 8 of the two's-complement difference is the borrow.
  // Logical ops leave bit 8 at zero, which clears Cy.
  always_comb begin
    alu_sum_s = 9'h000;
    case (aluop)
      OP_ADD:  alu_sum_s = {1'b0, t_q} + {1'b0, x_s};
      OP_SUB:  alu_sum_s = {1'b0, t_q} - {1'b0, x_s};
      OP_AND:  alu_sum_s = {1'b0, t_q & x_s};
      OP_OR:   alu_sum_s = {1'b0, t_q | x_s};
      OP_XOR:  alu_sum_s = {1'b0, t_q ^ x_s};
      OP_INC:  alu_sum_s = {1'b0, x_s} + 9'h001;
      OP_DEC:  alu_sum_s = {1'b0, x_s} - 9'h001;
      OP_PASS: alu_sum_s = {1'b0, x_s};
      OP_NOT:  alu_sum_s = {1'b0, ~x_s};
      OP_SHL:  alu_sum_s = {x_s, 1'b0};
      // Cy comes from the bit that is shifted out, so it is patched below.
      OP_SHR:  alu_sum_s = {1'b0, 1'b0, x_s[7:1]};
      default: alu_sum_s = {1'b0, x_s};
    endcase
  end

  // ALU flag formation {S, Z, Cy}
  always_comb begin
    alu_res_s = alu_sum_s[7:0];
    alu_cy_s  = (aluop == OP_SHR) ? x_s[0] : alu_sum_s[8];
    alu_flg_s = {alu_res_s[7], (alu_res_s == 8'h00), alu_cy_s};
  end

  // Next-state selection: each register loads when its enable is set and
  // holds otherwise. Several enables may be active at once (broadcast).
  always_comb begin
    pc_d  = xdst[EN_PC]  ? x_s       : pc_q;
    a_d   = xdst[EN_A]   ? x_s       : a_q;
    b_d   = xdst[EN_B]   ? x_s       : b_q;
    c_d   = xdst[EN_C]   ? x_s       : c_q;
    ma_d  = xdst[EN_MA]  ? x_s       : ma_q;
    wd_d  = xdst[EN_WD]  ? x_s       : wd_q;
    i_d   = xdst[EN_I]   ? x_s       : i_q;
    t_d   = xdst[EN_T]   ? x_s       : t_q;
    r_d   = xdst[EN_R]   ? alu_res_s : r_q;
    flg_d = xdst[EN_FLG] ? alu_flg_s : flg_q;
  end

  // Datapath register bank. The ALU sees the pre-edge T, so loading T and R
  // on the same edge gives R = f(old T, X).
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc_q  <= 8'h00;
      a_q   <= 8'h00;
      b_q   <= 8'h00;
      c_q   <= 8'h00;
      ma_q  <= 8'h00;
      wd_q  <= 8'h00;
      i_q   <= 8'h00;
      t_q   <= 8'h00;
      r_q   <= 8'h00;
      flg_q <= 3'b000;
    end else begin
      pc_q  <= pc_d;
      a_q   <= a_d;
      b_q   <= b_d;
      c_q   <= c_d;
      ma_q  <= ma_d;
      wd_q  <= wd_d;
      i_q   <= i_d;
      t_q   <= t_d;
      r_q   <= r_d;
      flg_q <= flg_d;
    end
  end

  // Every output is a direct register tap.
  assign mem_addr  = ma_q;
  assign mem_wdata = wd_q;
  assign I         = i_q;
  assign SZCy      = flg_q;
  assign pc        = pc_q;
  assign a         = a_q;
  assign b         = b_q;
  assign c         = c_q;

`ifdef CYCLE_COUNTER_EN
  logic [15:0] cycles_q, cycles_d;

  // Cycle counter next state: hold while paused, otherwise count with natural
  // 16-bit wrap.
  always_comb begin
    cycles_d = pause_cc ? cycles_q : (cycles_q + 16'd1);
  end

  // Cycle counter register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cycles_q <= 16'h0000;
    end else begin
      cycles_q <= cycles_d;
    end
  end

  assign cycles = cycles_q;
`else
  // pause_cc has no function without the counter.
  logic unused_pause_s;
  assign unused_pause_s = pause_cc;
`endif

endmodule

// File: tb/tb_cdecv_datapath.sv
module tb_cdecv_datapath;

  logic        clock;
  logic        reset;
  logic [2:0]  xsrc;
  logic [9:0]  xdst;
  logic [3:0]  aluop;
  logic [7:0]  mem_rdata;
  logic        pause_cc;
  logic [7:0]  mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  I;
  logic [2:0]  SZCy;
  logic [7:0]  pc;
  logic [7:0]  a;
  logic [7:0]  b;
  logic [7:0]  c;
`ifdef CYCLE_COUNTER_EN
  logic [15:0] cycles;
`endif

  cdecv_datapath dut (
    .clock     (clock),
    .reset     (reset),
    .xsrc      (xsrc),
    .xdst      (xdst),
    .aluop     (aluop),
    .mem_rdata (mem_rdata),
    .pause_cc  (pause_cc),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .I         (I),
    .SZCy      (SZCy),
    .pc        (pc),
    .a         (a),
    .b         (b),
    .c         (c)
`ifdef CYCLE_COUNTER_EN
    ,
    .cycles    (cycles)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  localparam logic [9:0] D_PC = 10'h001;
  localparam logic [9:0] D_A  = 10'h002;
  localparam logic [9:0] D_B  = 10'h004;
  localparam logic [9:0] D_C  = 10'h008;
  localparam logic [9:0] D_MA = 10'h010;
  localparam logic [9:0] D_WD = 10'h020;
  localparam logic [9:0] D_I  = 10'h040;
  localparam logic [9:0] D_T  = 10'h080;
  localparam logic [9:0] D_R  = 10'h100;
  localparam logic [9:0] D_F  = 10'h200;

  // chk: 0 pc, 1 a, 2 b, 3 c, 4 I, 5 mem_addr, 6 mem_wdata, 7 {5'b0,SZCy}
  typedef struct {
    logic [2:0] xs;
    logic [9:0] xd;
    logic [3:0] op;
    logic [7:0] rd;
    int         chk;
    logic [7:0] exp;
  } vec_t;

  localparam int NV = 39;
  vec_t tbl [NV];

  int n_cmp;
  int n_bad;

  task automatic compare(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] observe(input int sel);
    case (sel)
      0:       return pc;
      1:       return a;
      2:       return b;
      3:       return c;
      4:       return I;
      5:       return mem_addr;
      6:       return mem_wdata;
      7:       return {5'b00000, SZCy};
      default: return 8'hXX;
    endcase
  endfunction

  // Drive a control word on the falling edge and let one rising edge occur.
  task automatic cycle(input logic [2:0] xs, input logic [9:0] xd,
                       input logic [3:0] op, input logic [7:0] rd);
    @(negedge clock);
    xsrc = xs; xdst = xd; aluop = op; mem_rdata = rd;
    @(posedge clock);
    #1;
  endtask

  task automatic idle_edges(input int n, input logic p);
    for (int k = 0; k < n; k++) begin
      @(negedge clock);
      xdst = 10'h000; pause_cc = p;
      @(posedge clock);
    end
    #1;
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    xsrc = 3'd0; xdst = 10'h000; aluop = 4'd0; mem_rdata = 8'h00; pause_cc = 1'b0;

    //            xsrc  xdst            op     rd     chk exp
    tbl[0]  = '{3'd7, D_A|D_B|D_MA,    4'd0,  8'h00, 1, 8'hFF};
    tbl[1]  = '{3'd0, 10'h000,         4'd0,  8'h00, 2, 8'hFF};
    tbl[2]  = '{3'd0, 10'h000,         4'd0,  8'h00, 5, 8'hFF};
    tbl[3]  = '{3'd0, 10'h000,         4'd0,  8'h00, 3, 8'h00};
    tbl[4]  = '{3'd4, D_T,             4'd0,  8'hF0, 1, 8'hFF};
    tbl[5]  = '{3'd4, D_A,             4'd0,  8'h20, 1, 8'h20};
    tbl[6]  = '{3'd1, D_R|D_F,         4'd0,  8'h00, 7, 8'h01};
    tbl[7]  = '{3'd5, D_B,             4'd0,  8'h00, 2, 8'h10};
    tbl[8]  = '{3'd4, D_T,             4'd0,  8'h33, 7, 8'h01};
    tbl[9]  = '{3'd4, D_R|D_F,         4'd1,  8'h33, 7, 8'h02};
    tbl[10] = '{3'd5, D_A,             4'd0,  8'h00, 1, 8'h00};
    tbl[11] = '{3'd4, D_T,             4'd0,  8'h01, 0, 8'h00};
    tbl[12] = '{3'd4, D_R|D_F,         4'd1,  8'h02, 7, 8'h05};
    tbl[13] = '{3'd5, D_WD,            4'd0,  8'h00, 6, 8'hFF};
    tbl[14] = '{3'd4, D_I|D_T|D_R,     4'd0,  8'hC3, 4, 8'hC3};
    tbl[15] = '{3'd5, D_PC,            4'd0,  8'h00, 0, 8'hC4};
    tbl[16] = '{3'd4, D_R|D_F,         4'd0,  8'h00, 7, 8'h04};
    tbl[17] = '{3'd5, D_A,             4'd0,  8'h00, 1, 8'hC3};
    tbl[18] = '{3'd7, D_R|D_F,         4'd5,  8'h00, 7, 8'h03};
    tbl[19] = '{3'd4, D_R|D_F,         4'd6,  8'h00, 7, 8'h05};
    tbl[20] = '{3'd4, D_R|D_F,         4'd9,  8'h81, 7, 8'h01};
    tbl[21] = '{3'd5, D_B,             4'd0,  8'h00, 2, 8'h02};
    tbl[22] = '{3'd4, D_R|D_F,         4'd10, 8'h81, 7, 8'h01};
    tbl[23] = '{3'd5, D_C,             4'd0,  8'h00, 3, 8'h40};
    tbl[24] = '{3'd4, D_R|D_F,         4'd2,  8'h0F, 7, 8'h00};
    tbl[25] = '{3'd5, D_A,             4'd0,  8'h00, 1, 8'h03};
    tbl[26] = '{3'd4, D_R|D_F,         4'd3,  8'h0F, 7, 8'h04};
    tbl[27] = '{3'd5, D_B,             4'd0,  8'h00, 2, 8'hCF};
    tbl[28] = '{3'd4, D_R|D_F,         4'd4,  8'hC3, 7, 8'h02};
    tbl[29] = '{3'd4, D_R|D_F,         4'd8,  8'h0F, 7, 8'h04};
    tbl[30] = '{3'd5, D_B,             4'd0,  8'h00, 2, 8'hF0};
    tbl[31] = '{3'd4, D_R|D_F,         4'd15, 8'h5A, 7, 8'h00};
    tbl[32] = '{3'd5, D_MA,            4'd0,  8'h00, 5, 8'h5A};
    tbl[33] = '{3'd4, D_R|D_F,         4'd6,  8'h00, 7, 8'h05};
    tbl[34] = '{3'd6, D_A,             4'd0,  8'h00, 1, 8'h05};
    tbl[35] = '{3'd3, D_PC,            4'd0,  8'h00, 0, 8'h40};
    tbl[36] = '{3'd2, D_WD,            4'd0,  8'h00, 6, 8'hF0};
    tbl[37] = '{3'd4, D_R|D_F,         4'd0,  8'h10, 7, 8'h04};
    tbl[38] = '{3'd5, D_I,             4'd0,  8'h00, 4, 8'hD3};

    // Power-on reset, released between edges
    reset = 1'b1;
    #12;
    compare("por_pc", {8'h00, pc}, 16'h0000);
    compare("por_flg", {13'h0000, SZCy}, 16'h0000);
    @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < NV; i++) begin
      cycle(tbl[i].xs, tbl[i].xd, tbl[i].op, tbl[i].rd);
      compare($sformatf("vec%0d", i), {8'h00, observe(tbl[i].chk)}, {8'h00, tbl[i].exp});
    end

    // Reset mid-run: preload A, then assert reset between edges
    cycle(3'd4, D_A, 4'd0, 8'h5A);
    compare("preload_a", {8'h00, a}, 16'h005A);
    xdst = 10'h000;
    #2;
    reset = 1'b1;
    #1;
    compare("rst_pc",  {8'h00, pc}, 16'h0000);
    compare("rst_a",   {8'h00, a},  16'h0000);
    compare("rst_b",   {8'h00, b},  16'h0000);
    compare("rst_c",   {8'h00, c},  16'h0000);
    compare("rst_i",   {8'h00, I},  16'h0000);
    compare("rst_ma",  {8'h00, mem_addr},  16'h0000);
    compare("rst_wd",  {8'h00, mem_wdata}, 16'h0000);
    compare("rst_flg", {13'h0000, SZCy},   16'h0000);
    @(negedge clock);
    reset = 1'b0;

`ifdef CYCLE_COUNTER_EN
    compare("cc_reset", cycles, 16'h0000);
    idle_edges(10, 1'b0);
    idle_edges(5, 1'b1);
    idle_edges(3, 1'b0);
    compare("cc_pause", cycles, 16'd13);
    idle_edges(65522, 1'b0);
    compare("cc_max", cycles, 16'hFFFF);
    idle_edges(1, 1'b0);
    compare("cc_wrap", cycles, 16'h0000);
`endif

    // Normal loads resume after reset; T was cleared, so R = 0 + FF
    cycle(3'd7, D_C|D_R, 4'd0, 8'h00);
    compare("post_rst_c", {8'h00, c}, 16'h00FF);
    compare("post_rst_a", {8'h00, a}, 16'h0000);
    cycle(3'd5, D_WD, 4'd0, 8'h00);
    compare("post_rst_r", {8'h00, mem_wdata}, 16'h00FF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
